rf_dump_unit: RTL

- Reads out the core's register file once the microprocessor `top` asserts done.
- Streams the contents as a byte-framed packet over a valid/ready interface: start byte, every register in ascending address order, then an 8-bit checksum.
- It is the read-side counterpart to bench-side RF preloading. It sits beside `top` and drives one extra RF read port (the port is supplied by the `top` integrator); verification and the board debug path consume its stream.

---
 rtl/rf_dump_pkg.sv | 27 ++
 rtl/rf_dump_csum.sv | 34 +++
 rtl/rf_dump_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rf_dump_pkg.sv
`default_nettype none
// =============================================================================
// Module      : rf_dump_pkg
// Description : Shared FSM encoding, frame header constant and frame-length
//               helper for the register-file dump stream.
// Revision    : 1.0 - initial release
// =============================================================================
package rf_dump_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        FETCH = 3'd2,
        SEND  = 3'd3,
        CSUM  = 3'd4,
        FIN   = 3'd5
    } dump_state_t;

    localparam logic [7:0] c_start_byte = 8'hA5;

    // Header + one byte per register + checksum.
    function automatic int frame_len(input int aw);
        return (2 ** aw) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_dump_csum.sv
`default_nettype none
// =============================================================================
// Module      : rf_dump_csum
// Description : DW-bit modular accumulator with synchronous clear and add
//               enable; overflow is discarded.
// Revision    : 1.0 - initial release
// =============================================================================
module rf_dump_csum #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          add_en,
    input  logic [DW-1:0] add_data,
    output logic [DW-1:0] sum
);

    logic [DW-1:0] r_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (clr) begin
            r_sum <= '0;
        end else if (add_en) begin
            r_sum <= r_sum + add_data;
        end
    end

    assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/rf_dump_unit.sv
`default_nettype none
// =============================================================================
// Module      : rf_dump_unit
// Description : Dumps the core register file as a framed valid/ready byte
//               stream (header, registers ascending, checksum) on done.
// Revision    : 1.0 - initial release
// =============================================================================
module rf_dump_unit
    import rf_dump_pkg::*;
#(
    parameter int            DW         = 8,
    parameter int            AW         = 3,
    parameter logic [DW-1:0] START_BYTE = DW'(c_start_byte)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          done,
    output logic [AW-1:0] rf_rd_addr,
    input  logic [DW-1:0] rf_rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          dump_done
);

    localparam logic [AW-1:0] c_last_addr = '1;

    dump_state_t   r_state;
    dump_state_t   w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_hold;
    logic [DW-1:0] w_acc;
    logic          w_clr;
    logic          w_add;

    rf_dump_csum #(
        .DW (DW)
    ) u_csum (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_clr),
        .add_en   (w_add),
        .add_data (rf_rd_data),
        .sum      (w_acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Address only advances on an accepted non-terminal register byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_hold <= '0;
        end else begin
            if (r_state == IDLE && done) begin
                r_addr <= '0;
            end else if (r_state == SEND && out_ready && r_addr != c_last_addr) begin
                r_addr <= r_addr + 1'b1;
            end
            if (r_state == FETCH) begin
                r_hold <= rf_rd_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        busy        = 1'b0;
        dump_done   = 1'b0;
        w_clr       = 1'b0;
        w_add       = 1'b0;
        case (r_state)
            IDLE: begin
                if (done) begin
                    w_state_nxt = HDR;
                    w_clr       = 1'b1;
                end
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = START_BYTE;
                busy      = 1'b1;
                if (out_ready) w_state_nxt = FETCH;
            end
            FETCH: begin
                busy        = 1'b1;
                w_add       = 1'b1;
                w_state_nxt = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = r_hold;
                busy      = 1'b1;
                if (out_ready) w_state_nxt = (r_addr == c_last_addr) ? CSUM : FETCH;
            end
            CSUM: begin
                out_valid = 1'b1;
                out_data  = w_acc;
                out_last  = 1'b1;
                busy      = 1'b1;
                if (out_ready) w_state_nxt = FIN;
            end
            FIN: begin
                // Held done must not start another frame.
                dump_done = 1'b1;
                if (!done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign rf_rd_addr = r_addr;

endmodule
`default_nettype wire
